// File: rtl/switch_debouncer_pkg.sv
// Shared types and limits for the switch debouncer: per-channel FSM state
// encoding and the minimum legal qualification length.
package switch_debouncer_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      RISE_WAIT = 2'd1,
      HIGH      = 2'd2,
      FALL_WAIT = 2'd3
   } deb_state_t;

   localparam int STABLE_CYCLES_MIN = 2;

endpackage : switch_debouncer_pkg

// File: rtl/switch_debouncer_channel.sv
// One debounced switch channel: 2-flop synchronizer, qualification FSM with
// stable-sample counter, registered clean level and rise/fall pulses.
module debounce_channel
   import switch_debouncer_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic sw_clean,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int                 CNT_W   = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);

   if (STABLE_CYCLES < STABLE_CYCLES_MIN) begin : g_bad_stable_cycles
      $error("debounce_channel: STABLE_CYCLES must be >= %0d", STABLE_CYCLES_MIN);
   end

   logic             s1_r, s2_r;
   deb_state_t       state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             clean_r, clean_s;
   logic             rise_r, rise_s;
   logic             fall_r, fall_s;

   // Synchronizer, FSM state, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_r    <= 1'b0;
         s2_r    <= 1'b0;
         state_r <= LOW;
         cnt_r   <= CNT_ZERO;
         clean_r <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         s1_r    <= sw_raw;
         s2_r    <= s1_r;
         state_r <= state_s;
         cnt_r   <= cnt_s;
         clean_r <= clean_s;
         rise_r  <= rise_s;
         fall_r  <= fall_s;
      end
   end

   // Next-state logic; a candidate change is dropped on the first contrary sample.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      clean_s = clean_r;
      rise_s  = 1'b0;
      fall_s  = 1'b0;
      case (state_r)
         LOW: begin
            if (s2_r) begin
               state_s = RISE_WAIT;
               cnt_s   = CNT_ONE;
            end else begin
               cnt_s   = CNT_ZERO;
            end
         end
         RISE_WAIT: begin
            if (s2_r) begin
               if (cnt_r == CNT_MAX) begin
                  state_s = HIGH;
                  cnt_s   = CNT_ZERO;
                  clean_s = 1'b1;
                  rise_s  = 1'b1;
               end else begin
                  cnt_s   = cnt_r + CNT_ONE;
               end
            end else begin
               state_s = LOW;
               cnt_s   = CNT_ZERO;
            end
         end
         HIGH: begin
            if (!s2_r) begin
               state_s = FALL_WAIT;
               cnt_s   = CNT_ONE;
            end else begin
               cnt_s   = CNT_ZERO;
            end
         end
         FALL_WAIT: begin
            if (!s2_r) begin
               if (cnt_r == CNT_MAX) begin
                  state_s = LOW;
                  cnt_s   = CNT_ZERO;
                  clean_s = 1'b0;
                  fall_s  = 1'b1;
               end else begin
                  cnt_s   = cnt_r + CNT_ONE;
               end
            end else begin
               state_s = HIGH;
               cnt_s   = CNT_ZERO;
            end
         end
         default: begin
            state_s = LOW;
            cnt_s   = CNT_ZERO;
            clean_s = 1'b0;
         end
      endcase
   end

   assign sw_clean = clean_r;
   assign rise     = rise_r;
   assign fall     = fall_r;
   assign busy     = (state_r == RISE_WAIT) || (state_r == FALL_WAIT);

endmodule : debounce_channel

// File: rtl/switch_debouncer.sv
// Multi-channel switch conditioner feeding the relay chain; one independent
// debounce_channel per switch input.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int CHANNELS      = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] sw_raw,
   output logic [CHANNELS-1:0] sw_clean,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] busy
);

   if (CHANNELS < 1) begin : g_bad_channels
      $error("switch_debouncer: CHANNELS must be >= 1");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .sw_raw   (sw_raw[i]),
         .sw_clean (sw_clean[i]),
         .rise     (rise[i]),
         .fall     (fall[i]),
         .busy     (busy[i])
      );
   end

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (CHANNELS=2, STABLE_CYCLES=4); inputs
// change on the falling edge, outputs are checked on the falling edge.
module tb_switch_debouncer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] sw_raw;
   logic [1:0] sw_clean, rise, fall, busy;

   int n_chk  = 0;
   int n_pass = 0;

   switch_debouncer #(.CHANNELS(2), .STABLE_CYCLES(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_raw   (sw_raw),
      .sw_clean (sw_clean),
      .rise     (rise),
      .fall     (fall),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end else begin
         n_pass++;
      end
   endtask

   // one rising edge, landing on the following falling edge
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   logic [13:0] pat;
   int          rise_cnt;
   int          rise_edge;
   int          fall_seen;

   initial begin
      rst_n  = 1'b0;
      sw_raw = 2'b11;
      @(negedge clk);

      // reset with inputs high
      step(3);
      check_val("rst_clean", sw_clean, 2'b00);
      check_val("rst_rise",  rise,     2'b00);
      check_val("rst_fall",  fall,     2'b00);
      check_val("rst_busy",  busy,     2'b00);
      rst_n = 1'b1;
      step(5);
      check_val("rel_busy_e4",  busy,     2'b11);
      check_val("rel_clean_e4", sw_clean, 2'b00);
      step(1);
      check_val("rel_clean_e5", sw_clean, 2'b11);
      check_val("rel_rise_e5",  rise,     2'b11);
      step(1);
      check_val("rel_rise_e6",  rise,     2'b00);

      // release channel 0
      sw_raw = 2'b10;
      step(5);
      check_val("fall_e4",       fall,     2'b00);
      check_val("fall_clean_e4", sw_clean, 2'b11);
      step(1);
      check_val("fall_e5",       fall,     2'b01);
      check_val("fall_clean_e5", sw_clean, 2'b10);
      check_val("fall_rise_e5",  rise,     2'b00);
      step(1);
      check_val("fall_e6",       fall,     2'b00);

      // clean press on channel 0
      sw_raw = 2'b11;
      step(2);
      check_val("press_busy_e1", busy, 2'b00);
      step(1);
      check_val("press_busy_e2", busy, 2'b01);
      step(2);
      check_val("press_busy_e4",  busy,     2'b01);
      check_val("press_clean_e4", sw_clean, 2'b10);
      step(1);
      check_val("press_clean_e5", sw_clean, 2'b11);
      check_val("press_rise_e5",  rise,     2'b01);
      check_val("press_busy_e5",  busy,     2'b00);
      step(1);
      check_val("press_rise_e6",  rise,     2'b00);

      // 2-cycle low glitch from HIGH
      fall_seen = 0;
      sw_raw = 2'b10;
      step(1);
      fall_seen |= fall[0];
      step(1);
      fall_seen |= fall[0];
      sw_raw = 2'b11;
      for (int k = 0; k < 10; k++) begin
         step(1);
         fall_seen |= fall[0];
      end
      check_val("glitch_nofall", fall_seen, 0);
      check_val("glitch_clean",  sw_clean,  2'b11);

      // bring channel 1 low to reach sw_clean=01
      sw_raw = 2'b01;
      step(8);
      check_val("pre_sim_clean", sw_clean, 2'b01);

      // simultaneous opposite changes
      sw_raw = 2'b10;
      step(5);
      check_val("sim_rise_e4", rise, 2'b00);
      check_val("sim_fall_e4", fall, 2'b00);
      step(1);
      check_val("sim_rise_e5",  rise,     2'b10);
      check_val("sim_fall_e5",  fall,     2'b01);
      check_val("sim_clean_e5", sw_clean, 2'b10);

      // bounce on channel 0: 1,1,0,1,0,1,1,1,...
      pat       = 14'b11111111101011;
      rise_cnt  = 0;
      rise_edge = -1;
      for (int i = 0; i < 14; i++) begin
         sw_raw = {1'b1, pat[i]};
         step(1);
         if (rise[0]) begin
            rise_cnt++;
            rise_edge = i;
         end
      end
      check_val("bounce_rise_cnt",  rise_cnt,  1);
      check_val("bounce_rise_edge", rise_edge, 10);
      check_val("bounce_clean",     sw_clean,  2'b11);

      // reset in the middle of a qualification
      sw_raw = 2'b10;
      step(8);
      check_val("pre_mid_clean", sw_clean, 2'b10);
      sw_raw = 2'b11;
      step(4);
      check_val("mid_busy_cnt2", busy, 2'b01);
      rst_n = 1'b0;
      step(2);
      check_val("mid_rst_clean", sw_clean, 2'b00);
      check_val("mid_rst_busy",  busy,     2'b00);
      rst_n = 1'b1;
      step(5);
      check_val("mid_clean_e4", sw_clean, 2'b00);
      check_val("mid_rise_e4",  rise,     2'b00);
      step(1);
      check_val("mid_rise_e5",  rise,     2'b11);
      check_val("mid_clean_e5", sw_clean, 2'b11);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_switch_debouncer

// File: doc/switch_debouncer.md
# switch_debouncer

Multi-channel switch conditioner that sits directly upstream of the relay chain. It turns raw, bouncing, asynchronous switch levels into clean, synchronous levels that drive relay control inputs. Each channel synchronizes its input, qualifies every level change with a stable-sample counter, and reports one-cycle rise and fall pulses alongside the clean level.

## Interface
Parameters:
- CHANNELS, default 2: number of independent switch channels (≥1).
- STABLE_CYCLES, default 4: consecutive identical synchronized samples needed to accept a level change (≥2).
- CNT_W, derived as $clog2(STABLE_CYCLES): counter width. Localparam; not overridable.

Ports (clock and reset first):
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- sw_raw  in  CHANNELS  raw switch levels; asynchronous, may bounce.
- sw_clean  out  CHANNELS  debounced level, registered; this output feeds the relay switch inputs.
- rise  out  CHANNELS  one-cycle pulse, asserted in the cycle sw_clean goes 0→1.
- fall  out  CHANNELS  one-cycle pulse, asserted in the cycle sw_clean goes 1→0.
- busy  out  CHANNELS  high while the channel is qualifying a candidate change.

## Operation
- Per channel, a 2-flop synchronizer (s1, s2) samples sw_raw. The FSM sees only s2.
- FSM states: LOW, RISE_WAIT, HIGH, FALL_WAIT. Each channel has its own counter cnt[CNT_W-1:0].
- LOW, s2=1: go to RISE_WAIT, cnt=1. Otherwise stay.
- RISE_WAIT, s2=1, cnt==STABLE_CYCLES-1: go to HIGH, sw_clean=1, rise=1, cnt=0.
- RISE_WAIT, s2=1, cnt below that value: cnt+1.
- RISE_WAIT, s2=0: go to LOW, cnt=0. No pulse is produced and sw_clean is unchanged.
- HIGH and FALL_WAIT mirror LOW and RISE_WAIT with s2 inverted. Completing FALL_WAIT sets sw_clean=0 and fall=1.
- busy = (state==RISE_WAIT or FALL_WAIT), decoded from the registered state.
- rise and fall are registered. They are high for exactly one cycle and are never both high on one channel.
- Channels are fully independent. Simultaneous events on different channels are processed in the same cycle with no interaction.

## Timing
- Reset (rst_n=0 at a clock edge): s1, s2, sw_clean, rise, fall, busy and cnt all go to 0, and state goes to LOW, regardless of sw_raw.
- Reset mid-qualification discards the pending change. If sw_raw is held at 1 through reset, qualification restarts from the first edge after rst_n returns to 1.
- Latency: raw level captured by s1 at edge 0. sw_clean and the pulse become visible after edge STABLE_CYCLES+1. That is edge 5 with the default.
- Minimum accepted pulse width: STABLE_CYCLES consecutive s2 samples. A shorter glitch produces no output change and no pulse.
- The counter never wraps. Its maximum value is STABLE_CYCLES-1.

## Structure
- Package switch_debouncer_pkg contains:
  - typedef enum deb_state_t {LOW, RISE_WAIT, HIGH, FALL_WAIT};
  - a STABLE_CYCLES_MIN=2 constant, checked by an elaboration-time assertion.
- Sub-module debounce_channel holds one synchronizer, one FSM and one counter. The top level instantiates it CHANNELS times in a generate loop. The top level holds no other logic.

## Test plan
All scenarios use STABLE_CYCLES=4 and CHANNELS=2.

- **Reset:** rst_n=0 for 3 cycles with sw_raw=2'b11 -> all outputs 0. After release, sw_clean=2'b11 at edge 5 after release, with rise=2'b11 for one cycle.
- **Clean press:** sw_raw[0] 0→1 captured at edge 0 and held -> busy[0] high after edges 2–4. sw_clean[0]=1 and rise[0]=1 after edge 5. rise[0]=0 after edge 6.
- **Bounce:** sw_raw[0] pattern 1,1,0,1,0,1,1,1,1,… (one value per cycle) -> no rise during the bounce. A single rise[0] occurs 5 edges after the final 0→1 capture.
- **Release:** channel 0 in HIGH, sw_raw[0] 1→0 held -> sw_clean[0]=0 and fall[0]=1 after edge 5. A 2-cycle 0 glitch from HIGH produces no fall.
- **Simultaneous channels:** sw_raw 2'b01→2'b10 in one cycle, from the state sw_clean=2'b01 -> rise[1] and fall[0] in the same cycle, 5 edges later.
- **Reset mid-qualification:** assert rst_n=0 while RISE_WAIT has cnt=2, keeping sw_raw[0]=1 -> sw_clean[0] stays 0. After release, rise[0] arrives at edge 5.
